param_stream_sink: RTL
======================

# param_stream_sink

Writable on-chip parameter buffer: the receiving end of the valid/ready parameter stream produced by the per-tensor `*_source` blocks. It accepts a stream of parameter beats (weights, biases) from a loader or upstream stage, stores them in an internal RAM, and serves them back through the same 2-cycle `address0`/`ce0`/`q0` read port used by the generated parameter ROMs. This lets a `*_source` block run unchanged on runtime-loaded parameters instead of `$readmemh` contents.

## Interface
- `PARAM_TENSOR_SIZE_DIM_0`, 32, tensor elements along dim 0
- `PARAM_TENSOR_SIZE_DIM_1`, 1, tensor elements along dim 1
- `PARAM_PRECISION_0`, 16, total bits per element
- `PARAM_PRECISION_1`, 3, fractional bits; carried only, no arithmetic on it
- `PARAM_PARALLELISM_DIM_0`, 1, lanes per beat along dim 0
- `PARAM_PARALLELISM_DIM_1`, 1, lanes per beat along dim 1
- `LANES`, `PARAM_PARALLELISM_DIM_0*PARAM_PARALLELISM_DIM_1`, elements per beat (derived)
- `IN_DEPTH`, `(DIM_0*DIM_1)/LANES`, beats per tensor (derived)
- `ADDR_WIDTH`, `$clog2(IN_DEPTH)+1`, read/write pointer width (derived)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `data_in`  in  `PARAM_PRECISION_0` × `LANES` (unpacked array)  beat lanes
- `data_in_valid`  in  1  beat valid
- `data_in_ready`  out  1  sink can accept a beat
- `load_start`  in  1  single-cycle pulse that starts or restarts a tensor load
- `load_done`  out  1  level; a complete tensor is stored
- `address0`  in  `ADDR_WIDTH`  read address (beat index)
- `ce0`  in  1  read pipeline enable
- `q0`  out  `PARAM_PRECISION_0*LANES`  packed beat; lane j at bits `[P*j+P-1 : P*j]`

## Operation
- FSM states: IDLE, LOAD, FULL. Reset puts the FSM in IDLE.
- **IDLE:** `data_in_ready`=0 and `load_done`=0. A `load_start` pulse moves to LOAD with `wr_ptr`=0.
- **LOAD:** `data_in_ready`=1.
  - Each handshake (`valid && ready`) writes the packed beat to `ram[wr_ptr]` and increments `wr_ptr`.
  - The handshake at `wr_ptr == IN_DEPTH-1` writes the last beat, clears `wr_ptr` to 0 and moves to FULL.
- **FULL:** `data_in_ready`=0 and `load_done`=1. Held until the next `load_start`.
- `load_start` in LOAD or FULL:
  - aborts or overwrites: moves to LOAD with `wr_ptr`=0 and drops `load_done` on the next cycle.
  - A beat presented in the same cycle as `load_start` is discarded (restart wins).
- Reads are legal in every state. `ram` itself is not reset. An `address0 >= IN_DEPTH` reads as all zeros.
- Packing: `q0[P*j +: P] = data_in[j]` for the beat written at that address.

## Timing
- Reset values: `data_in_ready`=0, `load_done`=0, `q0`=0, both read pipeline registers=0, `wr_ptr`=0.
- `rst` deasserted mid-LOAD returns the block to IDLE. Stored RAM words are kept, but `load_done` stays 0 until a full reload completes.
- Write latency:
  - A beat handshaken at edge N is readable by an `address0` sampled at edge N+1 or later.
  - Same-edge read/write to one address returns the old data.
- Read latency is 2 cycles, matching the parameter ROMs:
  - stage0 <= `ram[address0]` when `ce0`=1;
  - stage1 <= stage0 when `ce0`=1;
  - `q0` = stage1.
  - With `ce0`=0 both stages hold.
- `load_done` rises in the cycle after the last handshake and falls in the cycle after `load_start`.
- `data_in_ready` rises in the cycle after `load_start` and falls in the cycle after the last handshake.
- Throughput: one beat per cycle; `IN_DEPTH` cycles minimum per tensor under continuous valid.

## Configuration
- `PARAM_SINK_CHECKSUM_EN` defined:
  - adds output port `checksum` [`PARAM_PRECISION_0+8`-1:0];
  - on each handshake, all lanes are added into it as unsigned values, wrapping modulo 2^width;
  - it clears to 0 on `rst` and on `load_start`, and holds while FULL.
- Undefined: port absent, no accumulator logic.

## Test plan
- **Basic load/read.** Defaults (`IN_DEPTH`=32, 1 lane). Pulse `load_start`, stream values 0x0100+i for i=0..31 with continuous valid.
  - `load_done`=1 exactly 33 cycles after `load_start`.
  - Read address 5 with `ce0`=1 → `q0`=0x0105 two cycles later.
- **Backpressure / bubbles.** Toggle valid every other cycle.
  - Exactly 32 writes; `load_done` only after the 32nd handshake.
  - `data_in_ready`=0 in FULL, and extra beats there are ignored (readback unchanged).
- **Restart mid-load.** Load 10 beats of 0xAAAA, pulse `load_start`, then load 32 beats of 0x5555.
  - All 32 addresses read 0x5555.
  - `load_done` stays low until the 32nd beat after the restart.
- **Lane packing and range.** `PARALLELISM_DIM_0`=4, `IN_DEPTH`=8.
  - Beat {4,3,2,1} at index 2 → `q0[15:0]`=1 and `q0[63:48]`=4.
  - `address0`=8 → `q0`=0.
- **Async reset mid-load and ce0 stall.**
  - Assert `rst` asynchronously after beat 7: `data_in_ready` and `load_done` go low immediately and `q0`=0.
  - With `ce0`=0, `q0` holds its value across address changes.
- **Checksum (`PARAM_SINK_CHECKSUM_EN`).** Load 32 beats of 0xFFFF → `checksum`=0x1FFFE0; `checksum` clears to 0 after `load_start`.

Source files
------------

// File: rtl/param_stream_sink.sv
// Writable parameter buffer: stores a valid/ready stream of parameter beats, serves them on a 2-cycle ROM-style read port.
// Optional `PARAM_SINK_CHECKSUM_EN adds a running unsigned lane-sum output `checksum`.
module param_stream_sink #(
  parameter int PARAM_TENSOR_SIZE_DIM_0 = 32,
  parameter int PARAM_TENSOR_SIZE_DIM_1 = 1,
  parameter int PARAM_PRECISION_0       = 16,
  parameter int PARAM_PRECISION_1       = 3,
  parameter int PARAM_PARALLELISM_DIM_0 = 1,
  parameter int PARAM_PARALLELISM_DIM_1 = 1,
  localparam int LANES      = PARAM_PARALLELISM_DIM_0 * PARAM_PARALLELISM_DIM_1,
  localparam int IN_DEPTH   = (PARAM_TENSOR_SIZE_DIM_0 * PARAM_TENSOR_SIZE_DIM_1) / LANES,
  localparam int ADDR_WIDTH = $clog2(IN_DEPTH) + 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [PARAM_PRECISION_0-1:0]         data_in [LANES],
  input  logic                                 data_in_valid,
  output logic                                 data_in_ready,
  input  logic                                 load_start,
  output logic                                 load_done,
  input  logic [ADDR_WIDTH-1:0]                address0,
  input  logic                                 ce0,
  output logic [PARAM_PRECISION_0*LANES-1:0]   q0
`ifdef PARAM_SINK_CHECKSUM_EN
  ,
  output logic [PARAM_PRECISION_0+7:0]         checksum
`endif
);

  localparam int P         = PARAM_PRECISION_0;
  localparam int W         = P * LANES;
  localparam int RAM_AW    = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int RAM_WORDS = 1 << RAM_AW;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic                  r_ready;
  logic                  r_done;
  logic [W-1:0]          r_ram [RAM_WORDS];
  logic [W-1:0]          r_stage0;
  logic [W-1:0]          r_stage1;

  logic [W-1:0]          w_wr_word;
  logic                  w_wr_en;
  logic                  w_last;
  logic                  w_addr_ok;
  logic [RAM_AW-1:0]     w_rd_idx;
  logic [RAM_AW-1:0]     w_wr_idx;

  // A beat arriving together with load_start is dropped: the restart wins.
  assign w_wr_en   = r_ready && data_in_valid && !load_start;
  assign w_last    = (r_wr_ptr == ADDR_WIDTH'(IN_DEPTH - 1));
  assign w_addr_ok = (address0 < ADDR_WIDTH'(IN_DEPTH));
  assign w_rd_idx  = address0[RAM_AW-1:0];
  assign w_wr_idx  = r_wr_ptr[RAM_AW-1:0];

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_pack
      assign w_wr_word[P*gi +: P] = data_in[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_ready  <= 1'b0;
      r_done   <= 1'b0;
    end else if (load_start) begin
      r_state  <= S_LOAD;
      r_wr_ptr <= '0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_wr_en) begin
            if (w_last) begin
              r_state  <= S_FULL;
              r_wr_ptr <= '0;
              r_ready  <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_ram[w_wr_idx] <= w_wr_word;
    end
  end

  // Two-stage read pipeline mirrors the generated parameter ROMs; ce0 low freezes both stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage0 <= '0;
      r_stage1 <= '0;
    end else if (ce0) begin
      r_stage0 <= w_addr_ok ? r_ram[w_rd_idx] : '0;
      r_stage1 <= r_stage0;
    end
  end

  assign data_in_ready = r_ready;
  assign load_done     = r_done;
  assign q0            = r_stage1;

`ifdef PARAM_SINK_CHECKSUM_EN
  localparam int CW = P + 8;
  logic [CW-1:0] r_checksum;
  logic [CW-1:0] w_beat_sum;

  always_comb begin
    w_beat_sum = '0;
    for (int j = 0; j < LANES; j++) begin
      w_beat_sum = w_beat_sum + CW'(data_in[j]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_checksum <= '0;
    end else if (load_start) begin
      r_checksum <= '0;
    end else if (w_wr_en) begin
      r_checksum <= r_checksum + w_beat_sum;
    end
  end

  assign checksum = r_checksum;
`endif

endmodule
